// File: rtl/arith_ops_axil_engine.sv
// AXI4-Lite arithmetic engine: operand/control registers, a small IDLE/EXEC
// sequencer, a shift-add multiplier and a restoring divider. Results are
// read back through RES_LO/RES_HI, and a level interrupt is raised on done.
module arith_ops_axil_engine #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter bit FAST_MUL           = 1'b0
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              irq
);

  localparam int W  = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int WA = AW - 2;
  localparam int NB = W / 8;
  localparam int CW = $clog2(W + 1);

  typedef logic [WA-1:0] word_t;
  localparam word_t A_CTRL   = word_t'(0);
  localparam word_t A_STATUS = word_t'(1);
  localparam word_t A_OPA    = word_t'(2);
  localparam word_t A_OPB    = word_t'(3);
  localparam word_t A_RES_LO = word_t'(4);
  localparam word_t A_RES_HI = word_t'(5);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_DIV = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_OR  = 3'd5;
  localparam logic [2:0] OP_XOR = 3'd6;
  localparam logic [2:0] OP_RSV = 3'd7;

  localparam logic [1:0]    RESP_OKAY   = 2'b00;
  localparam logic [1:0]    RESP_SLVERR = 2'b10;
  localparam logic [CW-1:0] CNT_DONE    = CW'(W);

  generate
    if (C_S_AXI_DATA_WIDTH != 32) begin : g_width_check
      $error("arith_ops_axil_engine supports C_S_AXI_DATA_WIDTH = 32 only");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_EXEC} state_t;
  state_t state_q, state_d;

  logic          awready_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]    bresp_q, rresp_q;
  logic [W-1:0]  rdata_q;
  logic [2:0]    opcode_q;
  logic          irq_en_q, done_q, div0_q, carry_q;
  logic [W-1:0]  opa_q, opb_q, res_lo_q, res_hi_q, work_hi_q, work_lo_q;
  logic [CW-1:0] cnt_q;

  // Byte-lane merge of a write into an existing register value
  function automatic logic [W-1:0] apply_strb(input logic [W-1:0] old_v,
                                               input logic [W-1:0] new_v,
                                               input logic [NB-1:0] strb);
    logic [W-1:0] r;
    r = old_v;
    for (int b = 0; b < NB; b++) begin
      if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

  word_t wword, rword;
  logic  busy, wr_fire, rd_fire, start_req, wr_err, wr_ok, start_acc;
  logic  multi_cycle, finish;

  assign wword     = S_AXI_AWADDR[AW-1:2];
  assign rword     = S_AXI_ARADDR[AW-1:2];
  assign busy      = (state_q == S_EXEC);
  assign wr_fire   = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire   = arready_q & S_AXI_ARVALID;
  assign start_req = (wword == A_CTRL) & S_AXI_WSTRB[0] & S_AXI_WDATA[0];
  assign wr_err    = (wword > A_RES_HI) | (wword == A_RES_LO) | (wword == A_RES_HI)
                   | (busy & ((wword == A_CTRL) | (wword == A_OPA) | (wword == A_OPB)))
                   | (start_req & (S_AXI_WDATA[3:1] == OP_RSV));
  assign wr_ok     = wr_fire & ~wr_err;
  assign start_acc = wr_ok & start_req;

  // Only sequential MUL and DIV with a non-zero divisor iterate; all else finishes in one cycle
  assign multi_cycle = ((opcode_q == OP_MUL) & ~FAST_MUL) |
                       ((opcode_q == OP_DIV) & (opb_q != '0));
  assign finish      = busy & (~multi_cycle | (cnt_q == CNT_DONE));

  logic [W:0]     add_w, sub_w, mul_sum, div_t, div_diff;
  logic           div_ge;
  logic [2*W-1:0] prod_w;

  assign add_w    = {1'b0, opa_q} + {1'b0, opb_q};
  assign sub_w    = {1'b0, opa_q} - {1'b0, opb_q};
  assign mul_sum  = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, opa_q} : '0);
  assign div_t    = {work_hi_q, work_lo_q[W-1]};
  assign div_ge   = (div_t >= {1'b0, opb_q});
  assign div_diff = div_t - {1'b0, opb_q};
  assign prod_w   = {{W{1'b0}}, opa_q} * {{W{1'b0}}, opb_q};

  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[1:0], div_diff[W]};

  // One iteration of shift-add multiply or restoring divide on the work pair
  logic [W-1:0] step_hi_d, step_lo_d;
  always_comb begin
    step_hi_d = work_hi_q;
    step_lo_d = work_lo_q;
    if (opcode_q == OP_MUL) begin
      step_hi_d = mul_sum[W:1];
      step_lo_d = {mul_sum[0], work_lo_q[W-1:1]};
    end else if (opcode_q == OP_DIV) begin
      step_hi_d = div_ge ? div_diff[W-1:0] : div_t[W-1:0];
      step_lo_d = {work_lo_q[W-2:0], div_ge};
    end
  end

  // Result and flag values committed on the completion edge
  logic [W-1:0] res_lo_d, res_hi_d;
  logic         carry_d, div0_d;
  always_comb begin
    res_lo_d = '0;
    res_hi_d = '0;
    carry_d  = 1'b0;
    div0_d   = 1'b0;
    case (opcode_q)
      OP_ADD: begin
        res_lo_d = add_w[W-1:0];
        res_hi_d = {{(W-1){1'b0}}, add_w[W]};
        carry_d  = add_w[W];
      end
      OP_SUB: begin
        res_lo_d = sub_w[W-1:0];
        res_hi_d = {{(W-1){1'b0}}, sub_w[W]};
        carry_d  = sub_w[W];
      end
      OP_MUL: begin
        if (FAST_MUL) {res_hi_d, res_lo_d} = prod_w;
        else          {res_hi_d, res_lo_d} = {work_hi_q, work_lo_q};
      end
      OP_DIV: begin
        if (opb_q == '0) begin
          res_lo_d = '1;
          res_hi_d = opa_q;
          div0_d   = 1'b1;
        end else begin
          res_lo_d = work_lo_q;
          res_hi_d = work_hi_q;
        end
      end
      OP_AND:  res_lo_d = opa_q & opb_q;
      OP_OR:   res_lo_d = opa_q | opb_q;
      OP_XOR:  res_lo_d = opa_q ^ opb_q;
      default: ;
    endcase
  end

  // Read-data mux; unmapped words return zero with an error response
  logic [W-1:0] rd_data_c;
  logic         rd_err_c;
  always_comb begin
    rd_data_c = '0;
    rd_err_c  = 1'b0;
    case (rword)
      A_CTRL:   rd_data_c[4:0] = {irq_en_q, opcode_q, 1'b0};
      A_STATUS: rd_data_c[3:0] = {carry_q, div0_q, done_q, busy};
      A_OPA:    rd_data_c      = opa_q;
      A_OPB:    rd_data_c      = opb_q;
      A_RES_LO: rd_data_c      = res_lo_q;
      A_RES_HI: rd_data_c      = res_hi_q;
      default:  rd_err_c       = 1'b1;
    endcase
  end

  // Sequencer next state: leave IDLE on an accepted start, return once the op completes
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_acc) state_d = S_EXEC;
      S_EXEC:  if (finish)    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Write address/data accept pulse and write response
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      awready_q <= ~awready_q & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q;
      if (wr_fire) begin
        bvalid_q <= 1'b1;
        bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
      end else if (bvalid_q & S_AXI_BREADY) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  // Read address accept pulse and registered read data, captured from pre-edge state
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      arready_q <= ~arready_q & S_AXI_ARVALID & ~rvalid_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_data_c;
        rresp_q  <= rd_err_c ? RESP_SLVERR : RESP_OKAY;
      end else if (rvalid_q & S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  // Register writes, operation launch, iteration and completion (completion overrides W1C)
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      opcode_q  <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
      carry_q   <= 1'b0;
      opa_q     <= '0;
      opb_q     <= '0;
      res_lo_q  <= '0;
      res_hi_q  <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (wr_ok) begin
        case (wword)
          A_CTRL: if (S_AXI_WSTRB[0]) begin
            opcode_q <= S_AXI_WDATA[3:1];
            irq_en_q <= S_AXI_WDATA[4];
          end
          A_STATUS: if (S_AXI_WSTRB[0] & S_AXI_WDATA[1]) done_q <= 1'b0;
          A_OPA:    opa_q <= apply_strb(opa_q, S_AXI_WDATA, S_AXI_WSTRB);
          A_OPB:    opb_q <= apply_strb(opb_q, S_AXI_WDATA, S_AXI_WSTRB);
          default:  ;
        endcase
      end
      if (start_acc) begin
        done_q    <= 1'b0;
        div0_q    <= 1'b0;
        carry_q   <= 1'b0;
        cnt_q     <= '0;
        work_hi_q <= '0;
        work_lo_q <= (S_AXI_WDATA[3:1] == OP_MUL) ? opb_q : opa_q;
      end
      if (finish) begin
        res_lo_q <= res_lo_d;
        res_hi_q <= res_hi_d;
        done_q   <= 1'b1;
        div0_q   <= div0_d;
        carry_q  <= carry_d;
      end else if (busy) begin
        work_hi_q <= step_hi_d;
        work_lo_q <= step_lo_d;
        cnt_q     <= cnt_q + CW'(1);
      end
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign irq           = done_q & irq_en_q;

endmodule
